// File: rtl/fxu_pkg.sv
//==============================================================================
// Module  : fxu_pkg
// Purpose : Opcodes and CDB message type shared by the FXU, ROB and stations.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package fxu_pkg;

  localparam int CDB_DATA_W = 16;
  localparam int CDB_IDX_W  = 4;

  localparam logic [3:0] OP_SUB  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SHL  = 4'h5;
  localparam logic [3:0] OP_SHR  = 4'h6;
  localparam logic [3:0] OP_MOVL = 4'h8;
  localparam logic [3:0] OP_MOVH = 4'h9;

  typedef struct packed {
    logic                  valid;
    logic [CDB_IDX_W-1:0]  index;
    logic [CDB_DATA_W-1:0] result;
  } cdb_msg_t;

endpackage

`default_nettype wire

// File: rtl/fxu_alu.sv
//==============================================================================
// Module  : fxu_alu
// Purpose : Combinational FXU datapath. FXU_EXT_OPS_EN enables ADD/logic/shifts.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module fxu_alu
  import fxu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  localparam int SH_W = $clog2(DATA_W);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_SUB:  result = op1 - op2;
      OP_MOVL: result = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      // MOVH keeps the low byte of the old destination value
      OP_MOVH: result = {imm, op1[DATA_W-IMM_W-1:0]};
`ifdef FXU_EXT_OPS_EN
      OP_ADD:  result = op1 + op2;
      OP_AND:  result = op1 & op2;
      OP_OR:   result = op1 | op2;
      OP_XOR:  result = op1 ^ op2;
      OP_SHL:  result = op1 << op2[SH_W-1:0];
      OP_SHR:  result = op1 >> op2[SH_W-1:0];
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fxu_exec.sv
//==============================================================================
// Module  : fxu_exec
// Purpose : Fixed-point execution unit; LATENCY-deep pipeline onto a CDB slot.
//           Optional ops via FXU_EXT_OPS_EN (see fxu_alu).
// Rev     : 1.0
//==============================================================================
`default_nettype none

module fxu_exec
  import fxu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ROB_IDX_W = 4,
  parameter int IMM_W     = 8,
  parameter int LATENCY   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           opcode,
  input  logic [ROB_IDX_W-1:0] instr_index,
  input  logic                 valid,
  input  logic [DATA_W-1:0]    op1,
  input  logic [DATA_W-1:0]    op2,
  input  logic [IMM_W-1:0]     imm,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_index,
  output logic [DATA_W-1:0]    cdb_result,
  output logic                 illegal_op
);

  generate
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("fxu_exec: LATENCY must be in 1..4");
    end
    if (DATA_W != CDB_DATA_W || ROB_IDX_W != CDB_IDX_W) begin : g_bad_width
      $error("fxu_exec: DATA_W/ROB_IDX_W must match the CDB message layout");
    end
  endgenerate

  logic [DATA_W-1:0] alu_result;
  logic              alu_illegal;

  fxu_alu #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_alu (
    .opcode  (opcode),
    .op1     (op1),
    .op2     (op2),
    .imm     (imm),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  cdb_msg_t stage_d   [LATENCY];
  cdb_msg_t stage_q   [LATENCY];
  logic     illegal_d [LATENCY];
  logic     illegal_q [LATENCY];

  // Bubbles carry zeros so the shared bus stays clean
  always_comb begin
    stage_d[0].valid  = valid;
    stage_d[0].index  = valid ? instr_index : '0;
    stage_d[0].result = valid ? alu_result  : '0;
    illegal_d[0]      = valid & alu_illegal;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i]   = stage_q[i-1];
      illegal_d[i] = illegal_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i]   <= '0;
        illegal_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i]   <= stage_d[i];
        illegal_q[i] <= illegal_d[i];
      end
    end
  end

  assign cdb_valid  = stage_q[LATENCY-1].valid;
  assign cdb_index  = stage_q[LATENCY-1].index;
  assign cdb_result = stage_q[LATENCY-1].result;
  assign illegal_op = illegal_q[LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_fxu_exec.sv
//==============================================================================
// Module  : tb_fxu_exec
// Purpose : Scoreboard bench driving LATENCY=1 and LATENCY=3 units in parallel.
// Rev     : 1.0
//==============================================================================
`default_nettype none

module tb_fxu_exec;

`ifdef FXU_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [3:0]  idx;
    logic [15:0] res;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  opcode = '0;
  logic [3:0]  instr_index = '0;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;
  logic [7:0]  imm = '0;

  logic        v1, il1, v3, il3;
  logic [3:0]  ix1, ix3;
  logic [15:0] r1, r3;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  exp_t sb [2][$];

  fxu_exec #(.DATA_W(16), .ROB_IDX_W(4), .IMM_W(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_index(instr_index),
    .valid(valid), .op1(op1), .op2(op2), .imm(imm),
    .cdb_valid(v1), .cdb_index(ix1), .cdb_result(r1), .illegal_op(il1)
  );

  fxu_exec #(.DATA_W(16), .ROB_IDX_W(4), .IMM_W(8), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .instr_index(instr_index),
    .valid(valid), .op1(op1), .op2(op2), .imm(imm),
    .cdb_valid(v3), .cdb_index(ix3), .cdb_result(r3), .illegal_op(il3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: {illegal, result} straight from the opcode table
  function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [7:0] im);
    int ia = int'(a);
    int ib = int'(b);
    int sh = ib % 16;
    if (!EXT && op >= 4'd1 && op <= 4'd6) return 17'h10000;
    case (op)
      4'd0:    return {1'b0, 16'(ia - ib)};
      4'd1:    return {1'b0, 16'(ia + ib)};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      4'd5:    return {1'b0, 16'(ia << sh)};
      4'd6:    return {1'b0, 16'(ia >> sh)};
      4'd8:    return {1'b0, 16'(int'($signed(im)))};
      4'd9:    return {1'b0, 16'(int'(im) * 256 + ia % 256)};
      default: return 17'h10000;
    endcase
  endfunction

  task automatic step(input logic r, input logic v, input logic [3:0] op,
                      input logic [3:0] idx, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] im, input logic [15:0] eres, input logic eill);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = r; valid = v; opcode = op; instr_index = idx; op1 = a; op2 = b; imm = im;
    for (int d = 0; d < 2; d++) begin
      if (!r) begin
        // anything due after the reset edge is lost
        while (sb[d].size() > 0 && sb[d][sb[d].size()-1].due > cyc)
          void'(sb[d].pop_back());
      end else if (v) begin
        e.due = cyc + lat(d);
        e.idx = idx;
        e.res = eres;
        e.ill = eill;
        sb[d].push_back(e);
      end
    end
  endtask

  task automatic send(input logic r, input logic v, input logic [3:0] op,
                      input logic [3:0] idx, input logic [15:0] a, input logic [15:0] b,
                      input logic [7:0] im);
    logic [16:0] m;
    m = model(op, a, b, im);
    step(r, v, op, idx, a, b, im, m[15:0], m[16]);
  endtask

  task automatic check_port(input int d, input logic v, input logic [3:0] ix,
                            input logic [15:0] r, input logic il);
    exp_t e;
    checks++;
    if (v === 1'b1) begin
      if (sb[d].size() == 0) begin
        errors++;
        $display("FAIL unexpected_bcast lat%0d cyc=%0d got idx=%0d res=%h ill=%b, required no broadcast",
                 lat(d), cyc, ix, r, il);
      end else begin
        e = sb[d].pop_front();
        if (e.due != cyc || e.idx !== ix || e.res !== r || e.ill !== il) begin
          errors++;
          $display("FAIL bcast lat%0d got cyc=%0d idx=%0d res=%h ill=%b, required cyc=%0d idx=%0d res=%h ill=%b",
                   lat(d), cyc, ix, r, il, e.due, e.idx, e.res, e.ill);
        end
      end
    end else begin
      if (v !== 1'b0 || ix !== 4'd0 || r !== 16'd0 || il !== 1'b0) begin
        errors++;
        $display("FAIL idle_bus lat%0d cyc=%0d got v=%b idx=%h res=%h ill=%b, required all zero",
                 lat(d), cyc, v, ix, r, il);
      end
      if (sb[d].size() > 0) begin
        checks++;
        if (sb[d][0].due <= cyc) begin
          errors++;
          $display("FAIL missing_bcast lat%0d cyc=%0d got none, required idx=%0d res=%h due=%0d",
                   lat(d), cyc, sb[d][0].idx, sb[d][0].res, sb[d][0].due);
          void'(sb[d].pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check_port(0, v1, ix1, r1, il1);
      check_port(1, v3, ix3, r3, il3);
    end
  end

  initial begin
    logic [3:0]  op;
    logic [15:0] a, b;
    // reset held two edges with valid high
    step(1'b0, 1'b1, 4'h0, 4'd9, 16'h1111, 16'h2222, 8'h33, 16'h0, 1'b0);
    step(1'b0, 1'b1, 4'h0, 4'd9, 16'h1111, 16'h2222, 8'h33, 16'h0, 1'b0);
    // directed cases with hand-derived expectations
    step(1'b1, 1'b1, 4'h0, 4'd5, 16'h0003, 16'h0005, 8'h00, 16'hFFFE, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'd0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 4'h8, 4'd1, 16'h0000, 16'h0000, 8'h80, 16'hFF80, 1'b0);
    step(1'b1, 1'b1, 4'h9, 4'd2, 16'hFF80, 16'h0000, 8'h12, 16'h1280, 1'b0);
    step(1'b1, 1'b0, 4'h0, 4'd0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 1'b0);
    step(1'b1, 1'b1, 4'hE, 4'd7, 16'h1234, 16'h0001, 8'h55, 16'h0000, 1'b1);
    step(1'b1, 1'b1, 4'h1, 4'd3, 16'h7FFF, 16'h0001, 8'h00, EXT ? 16'h8000 : 16'h0000, !EXT);
    // streaming SUBs with one bubble
    send(1'b1, 1'b1, 4'h0, 4'd0, 16'h0100, 16'h0001, 8'h00);
    send(1'b1, 1'b1, 4'h0, 4'd1, 16'h0000, 16'h0001, 8'h00);
    send(1'b1, 1'b0, 4'h0, 4'd0, 16'h0000, 16'h0000, 8'h00);
    send(1'b1, 1'b1, 4'h0, 4'd2, 16'h8000, 16'h7FFF, 8'h00);
    send(1'b1, 1'b1, 4'h0, 4'd3, 16'hFFFF, 16'hFFFF, 8'h00);
    for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 4'h0, 4'd0, 16'h0, 16'h0, 8'h0);
    // reset while two instructions are in flight
    send(1'b1, 1'b1, 4'h0, 4'd4, 16'h0050, 16'h0010, 8'h00);
    send(1'b1, 1'b1, 4'h8, 4'd5, 16'h0000, 16'h0000, 8'h7F);
    send(1'b0, 1'b1, 4'h0, 4'd6, 16'h0001, 16'h0001, 8'h00);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 4'h0, 4'd0, 16'h0, 16'h0, 8'h0);
    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 4'($urandom_range(0, 15));
        1:       op = 4'h0;
        2:       op = 4'($urandom_range(8, 9));
        default: op = 4'($urandom_range(1, 6));
      endcase
      a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      send($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, op,
           4'($urandom), a, b, 8'($urandom));
    end
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0, 4'h0, 4'd0, 16'h0, 16'h0, 8'h0);
    @(posedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (sb[d].size() != 0) begin
        errors++;
        $display("FAIL drain lat%0d got %0d pending, required 0", lat(d), sb[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fxu_exec.md
Name: fxu_exec

Overview:
- Fixed-point execution unit of the out-of-order core.
- Takes one issued instruction per cycle from its reservation station: opcode, ROB index, two 16-bit operand values and an 8-bit immediate.
- Computes the result and broadcasts {valid, ROB index, result} on its common-data-bus (CDB) slot.
- Two instances exist; they drive CDB slots 3 and 2, which feed the ROB and all reservation stations.

Parameters:
- DATA_W, 16, operand/result width.
- ROB_IDX_W, 4, ROB index width.
- IMM_W, 8, immediate width.
- LATENCY, 1, cycles from issue to CDB broadcast; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- opcode  in  4  instruction opcode.
- instr_index  in  ROB_IDX_W  ROB slot of the instruction.
- valid  in  1  issue strobe; inputs are sampled only when high.
- op1  in  DATA_W  operand A value (ra; for MOVH, the old rt value).
- op2  in  DATA_W  operand B value (rb).
- imm  in  IMM_W  immediate field.
- cdb_valid  out  1  result broadcast strobe.
- cdb_index  out  ROB_IDX_W  ROB slot of the broadcast result.
- cdb_result  out  DATA_W  result value.
- illegal_op  out  1  high with cdb_valid when the opcode is unsupported.

Behaviour:
- Reset: when rst_n=0 at a clock edge, every pipeline stage clears: cdb_valid=0, cdb_index=0, cdb_result=0, illegal_op=0. A reset mid-operation discards all in-flight instructions; nothing is broadcast for them.
- Fully pipelined:
  - Accepts one instruction every cycle and never stalls; there is no ready output.
  - The result of an instruction sampled at edge N appears on the outputs after edge N+LATENCY-1 and stays for exactly one cycle.
  - Throughput is 1 per cycle; instructions retire strictly in order.
- valid=0: a bubble enters the pipeline. cdb_valid=0 for that slot, and cdb_index/cdb_result are held at 0 so the bus is clean.
- Result is computed combinationally in stage 1, then carried through LATENCY-1 additional register stages alongside index and valid.
- Base opcodes:
  - 0x0 SUB: op1 - op2, modulo 2^16.
  - 0x8 MOVL: imm sign-extended to 16 bits.
  - 0x9 MOVH: {imm, op1[7:0]}.
- Any other opcode:
  - cdb_result=0 and illegal_op=1.
  - cdb_valid is still asserted so the ROB entry completes and does not hang.
- Arithmetic wraps silently. No flags are produced; branch and load/store opcodes never reach this unit, and if they do they are treated as illegal.
- Out-of-range LATENCY values are a synthesis-time error via a generate-time check.

Optional Feature:
- Macro FXU_EXT_OPS_EN. When defined, these opcodes become legal (illegal_op=0):
  - 0x1 ADD: op1 + op2, modulo 2^16.
  - 0x2 AND, 0x3 OR, 0x4 XOR: bitwise on op1, op2.
  - 0x5 SHL: op1 << op2[3:0].
  - 0x6 SHR: logical op1 >> op2[3:0].
- When undefined, opcodes 0x1–0x6 behave as illegal (result 0, illegal_op=1).
- Timing and handshake are identical in both builds.

Decomposition:
- Shared package fxu_pkg holds:
  - opcode localparams OP_SUB=4'h0, OP_ADD=4'h1, OP_AND=4'h2, OP_OR=4'h3, OP_XOR=4'h4, OP_SHL=4'h5, OP_SHR=4'h6, OP_MOVL=4'h8, OP_MOVH=4'h9;
  - a packed struct cdb_msg_t {valid, index, result}, reused by the ROB and reservation stations.
- One sub-module fxu_alu: purely combinational; inputs opcode, op1, op2, imm; outputs result and illegal.
- The top level holds only the LATENCY-deep register pipeline.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while driving valid=1 -> cdb_valid=0, cdb_index=0, cdb_result=0 throughout; first broadcast appears only LATENCY cycles after rst_n rises.
- SUB wrap (LATENCY=1): valid=1, opcode=0, index=5, op1=0x0003, op2=0x0005 -> next cycle cdb_valid=1, cdb_index=5, cdb_result=0xFFFE; following cycle cdb_valid=0.
- MOVL/MOVH back-to-back: MOVL imm=0x80 idx=1, then MOVH imm=0x12 op1=0xFF80 idx=2 -> consecutive broadcasts 0xFF80 (idx 1) and 0x1280 (idx 2).
- Illegal opcode 0xE, idx=7 -> cdb_valid=1, cdb_index=7, cdb_result=0, illegal_op=1. Under FXU_EXT_OPS_EN, opcode 0x1 with 0x7FFF+0x0001 -> 0x8000 and illegal_op=0.
- LATENCY=3 streaming: 4 consecutive valid SUBs (idx 0–3) with a bubble after the second -> results emerge in order exactly 3 cycles after each issue, with cdb_valid=0 in the bubble slot.
- Reset mid-flight (LATENCY=3): issue 2 instructions, assert rst_n=0 for one edge -> neither result is ever broadcast.
